// File: rtl/AXI_package.sv
// Shared coprocessor control definitions: register width, command and status
// codes, plus the sequencer state and result-code enumerations.
package AXI_package;

  localparam int REG_WIDTH = 32;

  localparam logic [REG_WIDTH-1:0] CMD_NOP                = 32'd0;
  localparam logic [REG_WIDTH-1:0] CMD_RESET              = 32'd1;
  localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 32'd2;
  localparam logic [REG_WIDTH-1:0] CMD_START              = 32'd3;
  localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 32'd4;
  localparam logic [REG_WIDTH-1:0] CMD_RESTART            = 32'd5;

  localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = 32'd0;
  localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = 32'd1;
  localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = 32'd2;
  localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = 32'd3;
  localparam logic [REG_WIDTH-1:0] STATUS_ERROR    = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WRITE,
    ST_START,
    ST_WAIT,
    ST_READ_CC,
    ST_RESTART,
    ST_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    RES_ACCEPT  = 2'd0,
    RES_REJECT  = 2'd1,
    RES_ERROR   = 2'd2,
    RES_TIMEOUT = 2'd3
  } result_code_e;

endpackage

// File: rtl/cmd_sequencer.sv
// Job sequencer for the coprocessor control block: loads a program, starts it,
// waits for a verdict (or a timeout), reads the elapsed clock and reports.
module cmd_sequencer
  import AXI_package::*;
#(
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int TIMEOUT_CYCLES  = 2**20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [PROG_ADDR_WIDTH:0]   job_prog_len,
  input  logic [REG_WIDTH-1:0]       job_start_cc,
  input  logic [REG_WIDTH-1:0]       job_end_cc,
  input  logic [REG_WIDTH-1:0]       prog_data,
  input  logic                       prog_valid,
  output logic                       prog_ready,
  output logic [REG_WIDTH-1:0]       data_in_register,
  output logic [REG_WIDTH-1:0]       address_register,
  output logic [REG_WIDTH-1:0]       start_cc_pointer_register,
  output logic [REG_WIDTH-1:0]       end_cc_pointer_register,
  output logic [REG_WIDTH-1:0]       cmd_register,
  input  logic [REG_WIDTH-1:0]       status_register,
  input  logic [REG_WIDTH-1:0]       data_o_register,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [1:0]                 result_code,
  output logic [REG_WIDTH-1:0]       result_elapsed
);

  localparam int TO_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LEN_W = PROG_ADDR_WIDTH + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  seq_state_e           r_state,  w_state_next;
  logic [LEN_W-1:0]     r_len,    w_len_next;
  logic [LEN_W-1:0]     r_beat,   w_beat_next;
  logic [TO_W-1:0]      r_timeout, w_timeout_next;
  logic                 r_job_ready, w_job_ready_next;
  logic                 r_prog_ready, w_prog_ready_next;
  logic [REG_WIDTH-1:0] r_data_in, w_data_in_next;
  logic [REG_WIDTH-1:0] r_addr, w_addr_next;
  logic [REG_WIDTH-1:0] r_start_cc, w_start_cc_next;
  logic [REG_WIDTH-1:0] r_end_cc, w_end_cc_next;
  logic [REG_WIDTH-1:0] r_cmd, w_cmd_next;
  logic                 r_result_valid, w_result_valid_next;
  result_code_e         r_result_code, w_result_code_next;
  logic [REG_WIDTH-1:0] r_result_elapsed, w_result_elapsed_next;

  logic             w_beat;
  logic [LEN_W-1:0] w_beat_inc;
  logic             w_timeout_hit;

  assign w_beat        = prog_valid & r_prog_ready;
  assign w_beat_inc    = r_beat + LEN_W'(1);
  assign w_timeout_hit = (r_timeout == TO_LAST);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    w_state_next          = r_state;
    w_len_next            = r_len;
    w_beat_next           = r_beat;
    w_timeout_next        = r_timeout;
    w_data_in_next        = r_data_in;
    w_addr_next           = r_addr;
    w_start_cc_next       = r_start_cc;
    w_end_cc_next         = r_end_cc;
    w_cmd_next            = CMD_NOP;
    w_result_valid_next   = 1'b0;
    w_result_code_next    = r_result_code;
    w_result_elapsed_next = r_result_elapsed;

    case (r_state)
      ST_IDLE: begin
        if (job_valid && r_job_ready) begin
          w_len_next      = job_prog_len;
          w_start_cc_next = job_start_cc;
          w_end_cc_next   = job_end_cc;
          w_beat_next     = '0;
          w_cmd_next      = CMD_RESET;
          w_state_next    = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        if (r_len != '0) begin
          w_state_next = ST_WRITE;
        end else begin
          w_cmd_next     = CMD_START;
          w_timeout_next = '0;
          w_state_next   = ST_START;
        end
      end

      ST_WRITE: begin
        if (w_beat) begin
          w_cmd_next     = CMD_WRITE;
          w_addr_next    = REG_WIDTH'(r_beat[PROG_ADDR_WIDTH-1:0]);
          w_data_in_next = prog_data;
          w_beat_next    = w_beat_inc;
          // The final write is still on the bus during the first START cycle.
          if (w_beat_inc == r_len) begin
            w_timeout_next = '0;
            w_state_next   = ST_START;
          end
        end
      end

      ST_START, ST_WAIT: begin
        if (w_timeout_hit) begin
          w_cmd_next            = CMD_RESET;
          w_result_code_next    = RES_TIMEOUT;
          w_result_elapsed_next = '0;
          w_result_valid_next   = 1'b1;
          w_state_next          = ST_DONE;
        end else begin
          w_timeout_next = r_timeout + TO_W'(1);
          if (r_state == ST_START) begin
            if (status_register == STATUS_RUNNING) begin
              w_state_next = ST_WAIT;
            end else begin
              w_cmd_next = CMD_START;
            end
          end else if (status_register == STATUS_ACCEPTED) begin
            w_result_code_next = RES_ACCEPT;
            w_cmd_next         = CMD_READ_ELAPSED_CLOCK;
            w_state_next       = ST_READ_CC;
          end else if (status_register == STATUS_REJECTED) begin
            w_result_code_next = RES_REJECT;
            w_cmd_next         = CMD_READ_ELAPSED_CLOCK;
            w_state_next       = ST_READ_CC;
          end else if (status_register == STATUS_ERROR) begin
            w_result_code_next = RES_ERROR;
            w_cmd_next         = CMD_READ_ELAPSED_CLOCK;
            w_state_next       = ST_READ_CC;
          end
        end
      end

      ST_READ_CC: begin
        w_result_elapsed_next = data_o_register;
        w_cmd_next            = CMD_RESTART;
        w_state_next          = ST_RESTART;
      end

      ST_RESTART: begin
        w_result_valid_next = 1'b1;
        w_state_next        = ST_DONE;
      end

      ST_DONE: begin
        if (result_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_result_valid_next = 1'b1;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase

    w_job_ready_next  = (w_state_next == ST_IDLE);
    w_prog_ready_next = (w_state_next == ST_WRITE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_len            <= '0;
      r_beat           <= '0;
      r_timeout        <= '0;
      r_job_ready      <= 1'b0;
      r_prog_ready     <= 1'b0;
      r_data_in        <= '0;
      r_addr           <= '0;
      r_start_cc       <= '0;
      r_end_cc         <= '0;
      r_cmd            <= CMD_NOP;
      r_result_valid   <= 1'b0;
      r_result_code    <= RES_ACCEPT;
      r_result_elapsed <= '0;
    end else begin
      r_state          <= w_state_next;
      r_len            <= w_len_next;
      r_beat           <= w_beat_next;
      r_timeout        <= w_timeout_next;
      r_job_ready      <= w_job_ready_next;
      r_prog_ready     <= w_prog_ready_next;
      r_data_in        <= w_data_in_next;
      r_addr           <= w_addr_next;
      r_start_cc       <= w_start_cc_next;
      r_end_cc         <= w_end_cc_next;
      r_cmd            <= w_cmd_next;
      r_result_valid   <= w_result_valid_next;
      r_result_code    <= w_result_code_next;
      r_result_elapsed <= w_result_elapsed_next;
    end
  end

  assign job_ready                 = r_job_ready;
  assign prog_ready                = r_prog_ready;
  assign data_in_register          = r_data_in;
  assign address_register          = r_addr;
  assign start_cc_pointer_register = r_start_cc;
  assign end_cc_pointer_register   = r_end_cc;
  assign cmd_register              = r_cmd;
  assign result_valid              = r_result_valid;
  assign result_code               = r_result_code;
  assign result_elapsed            = r_result_elapsed;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: drives inputs and samples outputs on the
// falling edge, with hand-computed expectations for every cycle checked.
module tb_cmd_sequencer;
  import AXI_package::*;

  localparam int PAW = 10;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 job_valid;
  logic                 job_ready;
  logic [PAW:0]         job_prog_len;
  logic [REG_WIDTH-1:0] job_start_cc, job_end_cc;
  logic [REG_WIDTH-1:0] prog_data;
  logic                 prog_valid, prog_ready;
  logic [REG_WIDTH-1:0] data_in_register, address_register;
  logic [REG_WIDTH-1:0] start_cc_pointer_register, end_cc_pointer_register;
  logic [REG_WIDTH-1:0] cmd_register;
  logic [REG_WIDTH-1:0] status_register, data_o_register;
  logic                 result_valid, result_ready;
  logic [1:0]           result_code;
  logic [REG_WIDTH-1:0] result_elapsed;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;

  always #5 clk = ~clk;

  cmd_sequencer #(.PROG_ADDR_WIDTH(PAW), .TIMEOUT_CYCLES(16)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .job_valid                 (job_valid),
    .job_ready                 (job_ready),
    .job_prog_len              (job_prog_len),
    .job_start_cc              (job_start_cc),
    .job_end_cc                (job_end_cc),
    .prog_data                 (prog_data),
    .prog_valid                (prog_valid),
    .prog_ready                (prog_ready),
    .data_in_register          (data_in_register),
    .address_register          (address_register),
    .start_cc_pointer_register (start_cc_pointer_register),
    .end_cc_pointer_register   (end_cc_pointer_register),
    .cmd_register              (cmd_register),
    .status_register           (status_register),
    .data_o_register           (data_o_register),
    .result_valid              (result_valid),
    .result_ready              (result_ready),
    .result_code               (result_code),
    .result_elapsed            (result_elapsed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and tally any write command on the bus.
  task automatic step();
    @(negedge clk);
    if (cmd_register == CMD_WRITE) n_writes++;
  endtask

  function automatic logic [31:0] word_of(input int i);
    return 32'hA0B0_C000 | 32'(i);
  endfunction

  task automatic submit(input int len, input logic [31:0] scc, input logic [31:0] ecc);
    job_prog_len = (PAW+1)'(len);
    job_start_cc = scc;
    job_end_cc   = ecc;
    job_valid    = 1'b1;
    for (int g = 0; g < 20 && !job_ready; g++) step();
    check("job_ready_wait", job_ready, 1'b1);
    step();
    job_valid = 1'b0;
    check("clear_cmd", cmd_register, CMD_RESET);
    check("clear_job_ready", job_ready, 1'b0);
    check("clear_start_cc", start_cc_pointer_register, scc);
    check("clear_end_cc", end_cc_pointer_register, ecc);
  endtask

  task automatic do_job(input int len, input logic [31:0] scc, input logic [31:0] ecc,
                        input bit gap, input logic [31:0] term, input int run_cycles,
                        input logic [31:0] cc_count, input logic [1:0] exp_code);
    n_writes = 0;
    submit(len, scc, ecc);
    for (int i = 0; i < len; i++) begin
      prog_valid = 1'b1;
      prog_data  = word_of(i);
      for (int g = 0; g < 20 && !prog_ready; g++) step();
      check("prog_ready_wait", prog_ready, 1'b1);
      step();
      check("write_cmd", cmd_register, CMD_WRITE);
      check("write_addr", address_register, 32'(i));
      check("write_data", data_in_register, word_of(i));
      if (gap && i == 0 && len > 1) begin
        prog_valid = 1'b0;
        step();
        check("gap_cmd", cmd_register, CMD_NOP);
        check("gap_prog_ready", prog_ready, 1'b1);
      end
    end
    prog_valid = 1'b0;
    step();
    check("start_cmd", cmd_register, CMD_START);
    check("start_prog_ready", prog_ready, 1'b0);
    check("start_held_cc", start_cc_pointer_register, scc);
    status_register = STATUS_RUNNING;
    step();
    check("wait_cmd", cmd_register, CMD_NOP);
    for (int k = 0; k < run_cycles; k++) step();
    status_register = term;
    data_o_register = 32'h0000_0BAD;
    step();
    check("readcc_cmd", cmd_register, CMD_READ_ELAPSED_CLOCK);
    data_o_register = cc_count;
    step();
    check("restart_cmd", cmd_register, CMD_RESTART);
    check("restart_valid", result_valid, 1'b0);
    data_o_register = 32'hDEAD_BEEF;
    status_register = STATUS_IDLE;
    step();
    check("done_valid", result_valid, 1'b1);
    check("done_cmd", cmd_register, CMD_NOP);
    check("done_code", result_code, exp_code);
    check("done_elapsed", result_elapsed, cc_count);
    check("done_end_cc", end_cc_pointer_register, ecc);
    step();
    check("hold_valid", result_valid, 1'b1);
    check("hold_code", result_code, exp_code);
    check("hold_elapsed", result_elapsed, cc_count);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("idle_valid", result_valid, 1'b0);
    check("idle_job_ready", job_ready, 1'b1);
    check("write_count", 32'(n_writes), 32'(len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    job_valid = 1'b0;
    job_prog_len = '0;
    job_start_cc = '0;
    job_end_cc = '0;
    prog_data = '0;
    prog_valid = 1'b0;
    status_register = STATUS_IDLE;
    data_o_register = '0;
    result_ready = 1'b0;
    repeat (3) step();
    check("rst_cmd", cmd_register, CMD_NOP);
    check("rst_job_ready", job_ready, 1'b0);
    check("rst_valid", result_valid, 1'b0);
    rst = 1'b0;
    step();
    check("post_rst_job_ready", job_ready, 1'b1);
    check("post_rst_prog_ready", prog_ready, 1'b0);

    // Three back-to-back words, accepting program.
    do_job(3, 32'd0, 32'd15, 1'b0, STATUS_ACCEPTED, 4, 32'd5, 2'd0);
    // Two words with a one-cycle gap, rejecting program.
    do_job(2, 32'd2, 32'd9, 1'b1, STATUS_REJECTED, 2, 32'h33, 2'd1);
    // Empty program, coprocessor reports an error.
    do_job(0, 32'd4, 32'd7, 1'b0, STATUS_ERROR, 0, 32'h1, 2'd2);

    // Timeout: empty program, coprocessor stuck RUNNING, terminal status on
    // the expiring cycle must lose to the timeout.
    n_writes = 0;
    submit(0, 32'd1, 32'd3);
    step();
    check("to_start_cmd", cmd_register, CMD_START);
    status_register = STATUS_RUNNING;
    for (int k = 1; k <= 15; k++) step();
    check("to_c15_cmd", cmd_register, CMD_NOP);
    check("to_c15_valid", result_valid, 1'b0);
    status_register = STATUS_ACCEPTED;
    step();
    check("to_c16_cmd", cmd_register, CMD_RESET);
    check("to_c16_valid", result_valid, 1'b1);
    check("to_code", result_code, 2'd3);
    check("to_elapsed", result_elapsed, 32'd0);
    status_register = STATUS_IDLE;
    step();
    check("to_done_cmd", cmd_register, CMD_NOP);
    check("to_done_valid", result_valid, 1'b1);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("to_idle_valid", result_valid, 1'b0);
    check("to_write_count", 32'(n_writes), 32'd0);

    // Reset while waiting on the coprocessor.
    submit(0, 32'd5, 32'd9);
    step();
    status_register = STATUS_RUNNING;
    step();
    check("rw_wait_cmd", cmd_register, CMD_NOP);
    step();
    rst = 1'b1;
    step();
    check("rw_cmd", cmd_register, CMD_NOP);
    check("rw_job_ready", job_ready, 1'b0);
    check("rw_prog_ready", prog_ready, 1'b0);
    check("rw_valid", result_valid, 1'b0);
    check("rw_start_cc", start_cc_pointer_register, 32'd0);
    check("rw_end_cc", end_cc_pointer_register, 32'd0);
    check("rw_addr", address_register, 32'd0);
    check("rw_data", data_in_register, 32'd0);
    check("rw_elapsed", result_elapsed, 32'd0);
    check("rw_code", result_code, 2'd0);
    rst = 1'b0;
    status_register = STATUS_ACCEPTED;
    step();
    check("rw_idle_ready", job_ready, 1'b1);
    step();
    check("rw_no_result", result_valid, 1'b0);
    status_register = STATUS_IDLE;
    do_job(1, 32'd6, 32'd12, 1'b0, STATUS_ACCEPTED, 1, 32'h77, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
